// File: rtl/trace_memory_ctrl.sv
// trace_memory_ctrl: trace RAM acting as a freezing ring buffer (trace mode) or a FIFO (stream mode),
// plus a one-word host-to-tracer load holding register.
module trace_memory_ctrl #(
    parameter int TRB_WIDTH = 32,
    parameter int TRB_DEPTH = 64,
    parameter int ADDR_BITS = $clog2(TRB_DEPTH)
) (
    input  logic                 FPGA_CLK_I,
    input  logic                 RST_I,
    input  logic                 MODE_I,
    input  logic                 TRG_EVENT_I,
    input  logic [ADDR_BITS-1:0] TRG_DELAY_I,
    output logic                 TRG_DELAYED_O,
    output logic [ADDR_BITS-1:0] TRIG_PTR_O,
    input  logic                 STORE_I,
    input  logic [TRB_WIDTH-1:0] DATA_I,
    output logic                 STORE_PERM_O,
    input  logic                 LOAD_REQUEST_I,
    output logic                 LOAD_GRANT_O,
    output logic [TRB_WIDTH-1:0] DATA_O,
    input  logic                 HOST_WR_I,
    input  logic [TRB_WIDTH-1:0] HOST_WR_DATA_I,
    output logic                 HOST_WR_READY_O,
    input  logic                 HOST_RD_I,
    output logic [TRB_WIDTH-1:0] HOST_RD_DATA_O,
    output logic                 HOST_RD_VALID_O,
    output logic [ADDR_BITS:0]   HOST_AVAIL_O
);
    localparam int CW = ADDR_BITS + 1;
    localparam logic [CW-1:0] FULL = CW'(TRB_DEPTH);

    logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];
    logic mode_q, mode_chg, rd_ok, store_ok, trig_now, freeze_now;
    logic [ADDR_BITS-1:0] dly_cur;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, dly_q, dly_d, trig_ptr_q, trig_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic wrapped_q, wrapped_d, armed_q, armed_d, frozen_q, frozen_d;
    logic ready_q, ready_d, grant_q, grant_d, rd_valid_q, rd_valid_d;
    logic [TRB_WIDTH-1:0] hold_q, hold_d, data_q, data_d, rd_data_q, rd_data_d;

    always_comb begin
        mode_chg   = MODE_I != mode_q;
        rd_ok      = !mode_chg && HOST_RD_I && count_q != '0 && (MODE_I || frozen_q);
        // a full FIFO still takes a store when a read frees the slot in the same cycle
        store_ok   = !mode_chg && STORE_I && (MODE_I ? (count_q != FULL || rd_ok) : !frozen_q);
        trig_now   = !MODE_I && TRG_EVENT_I && !armed_q;
        dly_cur    = trig_now ? '0 : dly_q;
        freeze_now = store_ok && !MODE_I && (armed_q || trig_now) && dly_cur == TRG_DELAY_I;
        wr_ptr_d   = wr_ptr_q + ADDR_BITS'(store_ok);
        wrapped_d  = wrapped_q || (store_ok && &wr_ptr_q);
        armed_d    = armed_q || trig_now;
        trig_ptr_d = trig_now ? wr_ptr_q : trig_ptr_q;
        dly_d      = (store_ok && armed_d) ? dly_cur + 1'b1 : dly_cur;
        frozen_d   = frozen_q || freeze_now;
        rd_ptr_d   = freeze_now ? (wrapped_d ? wr_ptr_d : '0) : rd_ptr_q + ADDR_BITS'(rd_ok);
        count_d    = MODE_I ? count_q + CW'(store_ok) - CW'(rd_ok)
                   : freeze_now ? (wrapped_d ? FULL : CW'(wr_ptr_d)) : count_q - CW'(rd_ok);
        rd_valid_d = rd_ok;
        rd_data_d  = rd_ok ? mem[rd_ptr_q] : rd_data_q;
        grant_d    = LOAD_REQUEST_I && !ready_q;
        data_d     = grant_d ? hold_q : data_q;
        hold_d     = (HOST_WR_I && ready_q) ? HOST_WR_DATA_I : hold_q;
        ready_d    = grant_d || (ready_q && !HOST_WR_I);
        if (mode_chg) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            armed_d    = 1'b0;
            trig_ptr_d = '0;
            dly_d      = '0;
            frozen_d   = 1'b0;
            hold_d     = '0;
            ready_d    = 1'b1;
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        mode_q <= MODE_I;
        if (RST_I) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            armed_q    <= 1'b0;
            trig_ptr_q <= '0;
            dly_q      <= '0;
            frozen_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            grant_q    <= 1'b0;
            data_q     <= '0;
            hold_q     <= '0;
            ready_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wrapped_q  <= wrapped_d;
            armed_q    <= armed_d;
            trig_ptr_q <= trig_ptr_d;
            dly_q      <= dly_d;
            frozen_q   <= frozen_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            ready_q    <= ready_d;
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (store_ok && !RST_I) mem[wr_ptr_q] <= DATA_I;
    end

    assign STORE_PERM_O    = MODE_I ? (count_q + CW'(STORE_I)) < FULL : !frozen_q;
    assign TRG_DELAYED_O   = frozen_q;
    assign TRIG_PTR_O      = trig_ptr_q;
    assign HOST_AVAIL_O    = count_q;
    assign HOST_RD_VALID_O = rd_valid_q;
    assign HOST_RD_DATA_O  = rd_data_q;
    assign LOAD_GRANT_O    = grant_q;
    assign DATA_O          = data_q;
    assign HOST_WR_READY_O = ready_q;
endmodule

// File: tb/tb_trace_memory_ctrl.sv
// tb_trace_memory_ctrl: directed trace/stream/load scenarios; host read data checked against a
// queue of expected words filled when each read is issued.
module tb_trace_memory_ctrl;
    localparam int W = 32;
    localparam int AB = 6;

    logic clk = 1'b0, rst = 1'b1, mode = 1'b0, trg = 1'b0, store = 1'b0, load_req = 1'b0;
    logic host_wr = 1'b0, host_rd = 1'b0;
    logic [AB-1:0] delay = '0;
    logic [W-1:0] din = '0, host_wr_data = '0;
    logic trg_delayed, store_perm, load_grant, host_wr_ready, host_rd_valid;
    logic [AB-1:0] trig_ptr;
    logic [W-1:0] dout, host_rd_data;
    logic [AB:0] host_avail;

    int errors = 0, checks = 0, vcount = 0;
    logic [W-1:0] exp_q[$];

    trace_memory_ctrl dut (
        .FPGA_CLK_I(clk), .RST_I(rst), .MODE_I(mode), .TRG_EVENT_I(trg), .TRG_DELAY_I(delay),
        .TRG_DELAYED_O(trg_delayed), .TRIG_PTR_O(trig_ptr), .STORE_I(store), .DATA_I(din),
        .STORE_PERM_O(store_perm), .LOAD_REQUEST_I(load_req), .LOAD_GRANT_O(load_grant),
        .DATA_O(dout), .HOST_WR_I(host_wr), .HOST_WR_DATA_I(host_wr_data),
        .HOST_WR_READY_O(host_wr_ready), .HOST_RD_I(host_rd), .HOST_RD_DATA_O(host_rd_data),
        .HOST_RD_VALID_O(host_rd_valid), .HOST_AVAIL_O(host_avail)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // every read-valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (host_rd_valid) begin
            vcount++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL rd_unexpected observed=%0h expected=none", host_rd_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                assert (host_rd_data === e) else begin
                    errors++;
                    $error("FAIL rd_data observed=%0h expected=%0h", host_rd_data, e);
                end
            end
        end
    end

    initial begin
        int v;
        tick(); tick();
        rst = 1'b0;
        chk("rst_delayed", trg_delayed, 0);
        chk("rst_perm", store_perm, 1);
        chk("rst_ready", host_wr_ready, 1);
        chk("rst_avail", host_avail, 0);
        chk("rst_trigptr", trig_ptr, 0);
        chk("rst_grant", load_grant, 0);

        // trace: delay 3, trigger with store #5
        delay = 3;
        for (int i = 0; i < 10; i++) begin
            store = 1'b1; din = W'(i); trg = (i >= 5);
            #1;
            if (i == 8) begin
                chk("t1_perm_before", store_perm, 1);
                chk("t1_delayed_before", trg_delayed, 0);
            end
            if (i == 9) chk("t1_perm_frozen", store_perm, 0);
            tick();
        end
        store = 1'b0;
        chk("t1_trigptr", trig_ptr, 5);
        chk("t1_delayed", trg_delayed, 1);
        chk("t1_avail", host_avail, 9);
        host_rd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(W'(i));
            tick();
        end
        host_rd = 1'b0;
        tick();
        chk("t1_avail_empty", host_avail, 0);
        host_rd = 1'b1; tick(); host_rd = 1'b0; tick();
        chk("t1_vcount", vcount, 9);

        // reset while frozen
        rst = 1'b1; tick(); rst = 1'b0; trg = 1'b0;
        chk("rst2_delayed", trg_delayed, 0);
        chk("rst2_perm", store_perm, 1);
        chk("rst2_avail", host_avail, 0);
        chk("rst2_trigptr", trig_ptr, 0);

        // trace: wrapped ring, maximum delay
        delay = '1;
        store = 1'b1;
        for (int i = 0; i < 100; i++) begin din = 32'h1000 + W'(i); tick(); end
        store = 1'b0; trg = 1'b1; tick();
        chk("t2_trigptr", trig_ptr, 36);
        store = 1'b1;
        for (int i = 100; i < 164; i++) begin
            din = 32'h1000 + W'(i);
            if (i == 163) chk("t2_delayed_before", trg_delayed, 0);
            tick();
        end
        din = 32'hDEAD_BEEF; tick(); store = 1'b0;
        chk("t2_delayed", trg_delayed, 1);
        chk("t2_avail", host_avail, 64);
        host_rd = 1'b1;
        for (int i = 100; i < 164; i++) begin
            exp_q.push_back(32'h1000 + W'(i));
            tick();
        end
        host_rd = 1'b0;
        tick();
        chk("t2_avail_empty", host_avail, 0);
        chk("t2_vcount", vcount, 73);

        // mode switch while frozen soft-resets the block
        mode = 1'b1; trg = 1'b0; tick();
        chk("mode_delayed", trg_delayed, 0);
        chk("mode_trigptr", trig_ptr, 0);
        chk("mode_avail", host_avail, 0);
        chk("mode_perm", store_perm, 1);

        // stream: read on empty, then store followed by read
        v = vcount;
        host_rd = 1'b1; tick(); host_rd = 1'b0; tick();
        chk("s_empty_read", vcount, v);
        store = 1'b1; din = 32'hCAFE_0000; tick(); store = 1'b0;
        chk("s_avail1", host_avail, 1);
        host_rd = 1'b1; exp_q.push_back(32'hCAFE_0000); tick(); host_rd = 1'b0;
        chk("s_latency_valid", host_rd_valid, 1);
        chk("s_latency_data", host_rd_data, 32'hCAFE_0000);
        tick();

        // stream: fill to full
        store = 1'b1;
        for (int i = 0; i < 64; i++) begin
            din = 32'h2000 + W'(i);
            #1;
            if (i == 62) chk("s_perm_62", store_perm, 1);
            if (i == 63) chk("s_perm_63", store_perm, 0);
            tick();
        end
        store = 1'b0; #1;
        chk("s_full_avail", host_avail, 64);
        chk("s_full_perm", store_perm, 0);
        store = 1'b1; din = 32'h2040; host_rd = 1'b1; exp_q.push_back(32'h2000); tick();
        store = 1'b0; host_rd = 1'b0;
        chk("s_rdwr_avail", host_avail, 64);
        host_rd = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            exp_q.push_back(32'h2000 + W'(i));
            tick();
        end
        host_rd = 1'b0;
        tick();
        chk("s_drained", host_avail, 0);

        // load path
        load_req = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); chk("ld_empty_nogrant", load_grant, 0); end
        host_wr = 1'b1; host_wr_data = 32'hA5A5_A5A5; tick(); host_wr = 1'b0;
        chk("ld_ready_low", host_wr_ready, 0);
        tick();
        chk("ld_grant", load_grant, 1);
        chk("ld_data", dout, 32'hA5A5_A5A5);
        chk("ld_ready_again", host_wr_ready, 1);
        tick();
        chk("ld_single_pulse", load_grant, 0);
        chk("ld_data_held", dout, 32'hA5A5_A5A5);
        host_wr = 1'b1; host_wr_data = 32'h1234_5678; tick(); host_wr = 1'b0;
        tick();
        chk("ld_grant2", load_grant, 1);
        host_wr = 1'b1; host_wr_data = 32'h0BAD_F00D; tick(); host_wr = 1'b0;
        chk("ld_refill_ready", host_wr_ready, 0);
        chk("ld_refill_nogrant", load_grant, 0);
        chk("ld_data2", dout, 32'h1234_5678);
        tick();
        chk("ld_grant3", load_grant, 1);
        chk("ld_data3", dout, 32'h0BAD_F00D);
        load_req = 1'b0;
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
